// File: rtl/status_register.sv
// Registered capture of the engine's error/busy/done flags into one status word,
// with an optional per-input synchronizer chain and an optional sticky error bit.
module status_register #(
    parameter int SYNC_STAGES  = 0,
    parameter int STICKY_ERROR = 0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       error_in,
    input  logic       busy_in,
    input  logic       done_in,
    output logic [2:0] status
);

    logic [2:0] raw_flags;
    logic [2:0] sync_flags;
    logic       error_next;

    assign raw_flags = {error_in, busy_in, done_in};

    generate
        if (SYNC_STAGES == 0) begin : g_no_sync
            assign sync_flags = raw_flags;
        end else begin : g_sync
            // Stage 0 faces the raw inputs; the last stage feeds the status register.
            logic [SYNC_STAGES-1:0][2:0] sync_q;

            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    sync_q <= '0;
                end else begin
                    // NOTE: non-blocking assignments let every stage sample its
                    // predecessor's old value, so the chain shifts by exactly one stage per edge.
                    sync_q[0] <= raw_flags;
                    for (int i = 1; i < SYNC_STAGES; i++) begin
                        sync_q[i] <= sync_q[i-1];
                    end
                end
            end

            assign sync_flags = sync_q[SYNC_STAGES-1];
        end
    endgenerate

    // Once latched, a sticky error can only be cleared by reset.
    always_comb begin
        error_next = sync_flags[2];
        if (STICKY_ERROR != 0) begin
            error_next = status[2] | sync_flags[2];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            status <= 3'b000;
        end else begin
            status <= {error_next, sync_flags[1:0]};
        end
    end

endmodule

// File: tb/tb_status_register.sv
// Scoreboard bench for status_register: three instances (default, two-stage sync,
// sticky error) share the inputs; stimulus queues expectations, a monitor checks them.
module tb_status_register;

    logic       clk;
    logic       rst;
    logic       error_in;
    logic       busy_in;
    logic       done_in;
    logic [2:0] status_plain;
    logic [2:0] status_sync2;
    logic [2:0] status_sticky;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    logic stk_model = 1'b0;

    typedef struct {
        int         due;
        int         id;
        logic [2:0] val;
    } exp_t;

    exp_t exp_q[$];

    status_register #(.SYNC_STAGES(0), .STICKY_ERROR(0)) u_plain (
        .clk(clk), .rst(rst), .error_in(error_in), .busy_in(busy_in),
        .done_in(done_in), .status(status_plain)
    );

    status_register #(.SYNC_STAGES(2), .STICKY_ERROR(0)) u_sync2 (
        .clk(clk), .rst(rst), .error_in(error_in), .busy_in(busy_in),
        .done_in(done_in), .status(status_sync2)
    );

    status_register #(.SYNC_STAGES(0), .STICKY_ERROR(1)) u_sticky (
        .clk(clk), .rst(rst), .error_in(error_in), .busy_in(busy_in),
        .done_in(done_in), .status(status_sticky)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    function automatic string dut_name(input int id);
        case (id)
            0:       return "plain";
            1:       return "sync2";
            default: return "sticky";
        endcase
    endfunction

    function automatic logic [2:0] dut_status(input int id);
        case (id)
            0:       return status_plain;
            1:       return status_sync2;
            default: return status_sticky;
        endcase
    endfunction

    task automatic check(input string name, input logic [2:0] actual, input logic [2:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("FAIL %s cyc=%0d got=%b expected=%b", name, cyc, actual, expected);
        end
    endtask

    function automatic void push_exp(input int id, input int lat, input logic [2:0] val);
        exp_t e;
        e.due = cyc + lat;
        e.id  = id;
        e.val = val;
        exp_q.push_back(e);
    endfunction

    // Applies one input vector (rst=1 assumed) and queues what each instance must show.
    task automatic apply(input logic [2:0] v);
        {error_in, busy_in, done_in} = v;
        stk_model = stk_model | v[2];
        push_exp(0, 1, v);
        push_exp(1, 3, v);
        push_exp(2, 1, {stk_model, v[1:0]});
    endtask

    task automatic drive(input logic [2:0] v);
        @(posedge clk);
        #1;
        apply(v);
    endtask

    task automatic check_all_now(input string name, input logic [2:0] expected);
        check({name, "_plain"},  status_plain,  expected);
        check({name, "_sync2"},  status_sync2,  expected);
        check({name, "_sticky"}, status_sticky, expected);
    endtask

    // Monitor: compares every due expectation at the falling edge.
    always @(negedge clk) begin
        for (int i = 0; i < exp_q.size(); ) begin
            if (exp_q[i].due == cyc) begin
                check(dut_name(exp_q[i].id), dut_status(exp_q[i].id), exp_q[i].val);
                exp_q.delete(i);
            end else if (exp_q[i].due < cyc) begin
                check({dut_name(exp_q[i].id), "_missed"}, 3'bxxx, exp_q[i].val);
                exp_q.delete(i);
            end else begin
                i++;
            end
        end
    end

    initial begin
        rst = 1'b0;
        {error_in, busy_in, done_in} = 3'b111;

        // Reset held with all inputs high and the clock running.
        repeat (4) begin
            @(posedge clk);
            #1;
            push_exp(0, 0, 3'b000);
            push_exp(1, 0, 3'b000);
            push_exp(2, 0, 3'b000);
        end

        // Release with inputs low.
        @(posedge clk);
        #1;
        rst = 1'b1;
        stk_model = 1'b0;
        apply(3'b000);

        // Walking set.
        drive(3'b100);
        drive(3'b110);
        drive(3'b111);

        // Partial clear.
        drive(3'b001);
        drive(3'b000);

        // Independence: all eight combinations on successive cycles.
        for (int k = 0; k < 8; k++) begin
            drive(3'(k));
        end

        // Let pipelines settle on 111, then reset mid-run between edges.
        repeat (4) @(posedge clk);
        #1;
        check_all_now("pre_reset", 3'b111);
        rst = 1'b0;
        #1;
        check_all_now("async_reset", 3'b000);

        // Release; sticky pulse then a single busy step for the latency check.
        @(posedge clk);
        #1;
        rst = 1'b1;
        stk_model = 1'b0;
        apply(3'b000);
        drive(3'b000);
        drive(3'b100);
        repeat (12) drive(3'b000);
        drive(3'b010);
        repeat (4) drive(3'b010);

        // Drain the scoreboard with a bounded wait.
        for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(posedge clk);
        if (exp_q.size() > 0) begin
            failures++;
            $display("FAIL scoreboard_drain pending=%0d expected=0", exp_q.size());
        end

        // Final reset clears the sticky error and holds status low.
        #1;
        rst = 1'b0;
        {error_in, busy_in, done_in} = 3'b111;
        #1;
        check_all_now("final_reset", 3'b000);
        repeat (3) begin
            @(negedge clk);
            check_all_now("final_hold", 3'b000);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
